fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory's 6-bit word address. It captures the returned 32-bit instruction into a registered IF/ID pipeline slot for the decode stage. It supports start/halt control, stall, flush and taken-branch redirect.

## Interface
- ADDR_W, 6: word-address width; the PC wraps modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded at reset.
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  level; begins fetching when in IDLE.
- Halt  in  1  level; stops fetching permanently until reset.
- Stall  in  1  holds the PC and the IF/ID slot.
- Flush  in  1  invalidates the IF/ID slot.
- BranchTaken  in  1  redirects the PC to BranchTarget.
- BranchTarget  in  ADDR_W  word address of the redirect.
- ReadAddress  out  ADDR_W  address to instruction memory; equals the PC.
- Instruction  in  32  combinational read data from instruction memory.
- IF_Instruction  out  32  registered instruction to decode.
- IF_PCPlus1  out  ADDR_W  registered (fetch PC + 1) mod 2^ADDR_W.
- IF_Valid  out  1  IF/ID slot holds a real instruction.
- Running  out  1  high while in RUN.
- FetchCount  out  16  (FETCH_PERF_EN only) count of instructions accepted into IF/ID.
- StallCount  out  16  (FETCH_PERF_EN only) count of RUN cycles with Stall high.

## Operation
- FSM states and transitions:
  - IDLE -> RUN when Start=1.
  - RUN -> HALT when Halt=1.
  - HALT is terminal; only reset exits it.
  - Halt in IDLE goes directly to HALT, and takes priority over Start.
- ReadAddress = PC, combinational from the PC register; no other logic in the path.
- IDLE and HALT behaviour: PC frozen; IF_Valid=0; IF_Instruction=0; Stall, Flush and Branch are ignored.
- RUN, per-cycle priority: BranchTaken > Stall > normal.
  - BranchTaken: PC <= BranchTarget. IF/ID slot cleared (IF_Valid=0, IF_Instruction=0, IF_PCPlus1=0). This applies regardless of Stall or Flush.
  - Stall (no branch): PC holds. IF/ID holds unless Flush=1, in which case the slot is cleared while the PC still holds.
  - Normal: PC <= PC+1 (wraps 2^ADDR_W-1 -> 0). IF_Instruction <= Instruction, IF_PCPlus1 <= PC+1, IF_Valid <= 1. If Flush=1, the slot is cleared instead, but the PC still advances.
- Halt arriving in the same cycle as other RUN inputs: that cycle's RUN update is still performed, then the FSM enters HALT. On the next cycle the IF/ID slot is cleared.
- Arithmetic is unsigned, ADDR_W bits, and truncating; no carry is exposed.

## Timing
- Reset values: PC=RESET_PC, state IDLE, IF_Instruction=0, IF_PCPlus1=0, IF_Valid=0, Running=0, counters 0. Reset takes effect immediately (asynchronous); release is synchronous to Clock.
- Latency: the instruction at address A appears on IF_Instruction one cycle after ReadAddress=A, provided the cycle was unstalled.
- Start is sampled at a rising edge. The first fetch of RESET_PC is captured at the edge following entry to RUN.
- Branch penalty: the fetch in the redirect cycle is discarded. The target's instruction is valid 2 edges after BranchTaken is sampled.
- Running is registered; it reflects the current state.
- Reset mid-operation returns everything to reset values at once, and any in-flight slot is lost.

## Configuration
- FETCH_PERF_EN defined:
  - FetchCount increments on each edge that sets IF_Valid from a normal fetch.
  - StallCount increments on each RUN edge with Stall=1 and BranchTaken=0.
  - Both saturate at 16'hFFFF and are reset by Reset_n.
- FETCH_PERF_EN undefined: both ports and all counter logic are absent; all other behaviour is identical.

## Test plan
- Reset then Start, memory loaded with 012A4020/02538822/00A62024/019D5825 at 0-3 -> IF_Instruction 012A4020, 02538822, 00A62024, 019D5825 on successive cycles; IF_PCPlus1 1,2,3,4; IF_Valid=1.
- Stall for 3 cycles at PC=2 -> ReadAddress stays 2; IF_Instruction holds 02538822; resumes 00A62024 after release. With FETCH_PERF_EN, StallCount=3.
- BranchTaken with BranchTarget=0 at PC=3, with Stall=1 in the same cycle -> next cycle IF_Valid=0, ReadAddress=0; following cycle IF_Instruction=012A4020.
- Flush with no stall at PC=1 -> IF_Valid=0 for one cycle; PC advances to 2; next instruction 00A62024 is valid.
- Run from PC=62 -> ReadAddress 62, 63, 0; IF_PCPlus1 for PC 63 = 0.
- Halt in RUN, then Start toggling -> Running=0, IF_Valid=0, PC frozen. Reset_n pulsed low mid-cycle -> all outputs return to zero immediately; PC=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: control inputs, instruction-memory bus and the IF/ID slot.
// Valid/ready: none; if_valid qualifies if_instruction/if_pcplus1 every cycle.
interface fetch_unit_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              halt;
  logic              stall;
  logic              flush;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] read_address;
  logic [31:0]       instruction;
  logic [31:0]       if_instruction;
  logic [ADDR_W-1:0] if_pcplus1;
  logic              if_valid;
  logic              running;

  modport master (
    input  start, halt, stall, flush, branch_taken, branch_target, instruction,
    output read_address, if_instruction, if_pcplus1, if_valid, running
  );

  modport slave (
    output start, halt, stall, flush, branch_taken, branch_target, instruction,
    input  read_address, if_instruction, if_pcplus1, if_valid, running
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IDLE/RUN/HALT control and the registered IF/ID slot.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter int                ADDR_W   = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus,
`ifdef FETCH_PERF_EN
  output logic [15:0]  fetch_count,
  output logic [15:0]  stall_count,
`endif
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [31:0]       slot_instr;
  logic [ADDR_W-1:0] slot_pcplus1;
  logic              slot_valid;
  logic              running_q;

  assign pc_inc             = pc + ADDR_W'(1);
  assign bus.read_address   = pc;
  assign bus.if_instruction = slot_instr;
  assign bus.if_pcplus1     = slot_pcplus1;
  assign bus.if_valid       = slot_valid;
  assign bus.running        = running_q;
  assign state_dbg          = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      slot_instr   <= '0;
      slot_pcplus1 <= '0;
      slot_valid   <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          slot_instr   <= '0;
          slot_pcplus1 <= '0;
          slot_valid   <= 1'b0;
          // Halt wins over Start so a halted part never issues a fetch.
          if (bus.halt) begin
            state <= HALT;
          end else if (bus.start) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.branch_taken) begin
            pc           <= bus.branch_target;
            slot_instr   <= '0;
            slot_pcplus1 <= '0;
            slot_valid   <= 1'b0;
          end else if (bus.stall) begin
            if (bus.flush) begin
              slot_instr   <= '0;
              slot_pcplus1 <= '0;
              slot_valid   <= 1'b0;
            end
          end else begin
            pc <= pc_inc;
            if (bus.flush) begin
              slot_instr   <= '0;
              slot_pcplus1 <= '0;
              slot_valid   <= 1'b0;
            end else begin
              slot_instr   <= bus.instruction;
              slot_pcplus1 <= pc_inc;
              slot_valid   <= 1'b1;
            end
          end
          // The RUN update above still lands in the halting cycle.
          if (bus.halt) begin
            state     <= HALT;
            running_q <= 1'b0;
          end
        end
        HALT: begin
          slot_instr   <= '0;
          slot_pcplus1 <= '0;
          slot_valid   <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          running_q    <= 1'b0;
          slot_instr   <= '0;
          slot_pcplus1 <= '0;
          slot_valid   <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_inc;
  logic stall_inc;

  assign fetch_inc = (state == RUN) && !bus.branch_taken && !bus.stall && !bus.flush;
  assign stall_inc = (state == RUN) && bus.stall && !bus.branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch_inc && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
      if (stall_inc && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of per-cycle stimulus with expected post-edge outputs,
// plus hand sequences for asynchronous reset and the perf counters.
module tb_fetch_unit;
  localparam int ADDR_W = 6;
  localparam int NV     = 28;
  localparam logic [31:0] IA = 32'h012A4020;
  localparam logic [31:0] IB = 32'h02538822;
  localparam logic [31:0] IC = 32'h00A62024;
  localparam logic [31:0] ID = 32'h019D5825;
  localparam logic [31:0] I62 = 32'hC0DE003E;
  localparam logic [31:0] I63 = 32'hC0DE003F;

  typedef struct packed {
    logic       start;
    logic       halt;
    logic       stall;
    logic       flush;
    logic       br;
    logic [5:0] tgt;
    logic [5:0] e_addr;
    logic       e_valid;
    logic [31:0] e_instr;
    logic [5:0] e_p1;
    logic       e_run;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  state_dbg;
  logic [31:0] mem [64];
  vec_t        vecs [NV];
  logic [45:0] exp_q [$];
  int          checks;
  int          errors;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
`ifdef FETCH_PERF_EN
    .fetch_count (fetch_count),
    .stall_count (stall_count),
`endif
    .state_dbg   (state_dbg)
  );

  assign bus.instruction = mem[bus.read_address];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic ha, input logic sl, input logic fl,
                              input logic br, input logic [5:0] tgt, input logic [5:0] addr,
                              input logic v, input logic [31:0] instr, input logic [5:0] p1,
                              input logic run);
    vec_t r;
    r.start = st; r.halt = ha; r.stall = sl; r.flush = fl; r.br = br; r.tgt = tgt;
    r.e_addr = addr; r.e_valid = v; r.e_instr = instr; r.e_p1 = p1; r.e_run = run;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ha, input logic sl, input logic fl,
                       input logic br, input logic [5:0] tgt);
    bus.start = st; bus.halt = ha; bus.stall = sl; bus.flush = fl;
    bus.branch_taken = br; bus.branch_target = tgt;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  32'(bus.read_address),   32'd0);
    check({tag, "_valid"}, 32'(bus.if_valid),       32'd0);
    check({tag, "_instr"}, bus.if_instruction,      32'd0);
    check({tag, "_p1"},    32'(bus.if_pcplus1),     32'd0);
    check({tag, "_run"},   32'(bus.running),        32'd0);
    check({tag, "_state"}, 32'(state_dbg),          32'd0);
  endtask

  // driver: apply one vector, push its expectation, pop and compare after the edge
  task automatic run_vec(input int i);
    logic [45:0] e;
    drive(vecs[i].start, vecs[i].halt, vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].tgt);
    exp_q.push_back({vecs[i].e_run, vecs[i].e_valid, vecs[i].e_p1, vecs[i].e_addr, vecs[i].e_instr});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("v%0d_addr", i),  32'(bus.read_address), 32'(e[37:32]));
    check($sformatf("v%0d_instr", i), bus.if_instruction,    e[31:0]);
    check($sformatf("v%0d_p1", i),    32'(bus.if_pcplus1),   32'(e[43:38]));
    check($sformatf("v%0d_valid", i), 32'(bus.if_valid),     32'(e[44]));
    check($sformatf("v%0d_run", i),   32'(bus.running),      32'(e[45]));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int a = 0; a < 64; a++) mem[a] = 32'hC0DE0000 + 32'(a);
    mem[0] = IA; mem[1] = IB; mem[2] = IC; mem[3] = ID;

    //            st ha sl fl br tgt | addr v instr p1 run
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,    0, 0, 0,   0, 1);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,    1, 1, IA,  1, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,    2, 1, IB,  2, 1);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0,    3, 1, IC,  3, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0,    4, 1, ID,  4, 1);
    vecs[5]  = mk(0, 0, 0, 0, 1, 1,    1, 0, 0,   0, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,    2, 1, IB,  2, 1);
    vecs[7]  = mk(0, 0, 1, 0, 0, 0,    2, 1, IB,  2, 1);
    vecs[8]  = mk(0, 0, 1, 0, 0, 0,    2, 1, IB,  2, 1);
    vecs[9]  = mk(0, 0, 1, 0, 0, 0,    2, 1, IB,  2, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 0,    3, 1, IC,  3, 1);
    vecs[11] = mk(0, 0, 1, 0, 1, 0,    0, 0, 0,   0, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0,    1, 1, IA,  1, 1);
    vecs[13] = mk(0, 0, 0, 1, 0, 0,    2, 0, 0,   0, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0,    3, 1, IC,  3, 1);
    vecs[15] = mk(0, 0, 0, 0, 1, 62,   62, 0, 0,  0, 1);
    vecs[16] = mk(0, 0, 0, 0, 0, 0,    63, 1, I62, 63, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0,    0, 1, I63, 0, 1);
    vecs[18] = mk(0, 0, 0, 0, 0, 0,    1, 1, IA,  1, 1);
    // after a mid-cycle reset
    vecs[19] = mk(1, 0, 0, 0, 0, 0,    0, 0, 0,   0, 1);
    vecs[20] = mk(0, 0, 0, 0, 0, 0,    1, 1, IA,  1, 1);
    vecs[21] = mk(0, 0, 1, 1, 0, 0,    1, 0, 0,   0, 1);
    vecs[22] = mk(0, 1, 0, 0, 0, 0,    2, 1, IB,  2, 0);
    vecs[23] = mk(1, 0, 1, 0, 1, 5,    2, 0, 0,   0, 0);
    vecs[24] = mk(0, 0, 0, 0, 0, 0,    2, 0, 0,   0, 0);
    // after another reset: Halt beats Start in IDLE
    vecs[25] = mk(1, 1, 0, 0, 0, 0,    0, 0, 0,   0, 0);
    vecs[26] = mk(1, 0, 0, 0, 0, 0,    0, 0, 0,   0, 0);
    vecs[27] = mk(0, 0, 0, 0, 1, 9,    0, 0, 0,   0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i <= 18; i++) begin
      run_vec(i);
`ifdef FETCH_PERF_EN
      if (i == 9) begin
        check("perf_stall3", 32'(stall_count), 32'd3);
        check("perf_fetch5", 32'(fetch_count), 32'd5);
      end
`endif
    end

    // asynchronous reset in the middle of a cycle, slot holding a valid instruction
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
`ifdef FETCH_PERF_EN
    check("midrst_fetch", 32'(fetch_count), 32'd0);
    check("midrst_stall", 32'(stall_count), 32'd0);
`endif
    #3;
    rst_n = 1'b1;

    for (int i = 19; i <= 24; i++) run_vec(i);
`ifdef FETCH_PERF_EN
    check("perf_fetch2", 32'(fetch_count), 32'd2);
    check("perf_stall1", 32'(stall_count), 32'd1);
`endif
    check("halt_state", 32'(state_dbg), 32'd2);

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 25; i < NV; i++) run_vec(i);
    check("idle_halt_state", 32'(state_dbg), 32'd2);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drain got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
